// File: rtl/vmem_pkg.sv
// Shared definitions for the vector/scalar RAM port controller: FSM encoding,
// requester tags and burst-length limits.
package vmem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic TAG_S = 1'b0;
  localparam logic TAG_V = 1'b1;

  localparam int MAX_BURST = 16;
  localparam int LEN_W     = 5;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

endpackage

// File: rtl/vmem_port_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: under contention the requester that was
// not granted most recently wins; an uncontended request wins immediately.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_s_i,
  input  logic req_v_i,
  output logic gnt_s_o,
  output logic gnt_v_o
);

  logic last_v_q, last_v_d;

  always_comb begin
    gnt_s_o = 1'b0;
    gnt_v_o = 1'b0;
    if (req_s_i && req_v_i) begin
      if (last_v_q) gnt_s_o = 1'b1;
      else          gnt_v_o = 1'b1;
    end else begin
      gnt_s_o = req_s_i;
      gnt_v_o = req_v_i;
    end
  end

  // Every grant, contended or not, moves the round-robin pointer.
  always_comb begin
    last_v_d = last_v_q;
    if (gnt_v_o)      last_v_d = 1'b1;
    else if (gnt_s_o) last_v_d = 1'b0;
  end

  // Reset points at the vector side so the scalar side wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_v_q <= 1'b1;
    else     last_v_q <= last_v_d;
  end

endmodule

// File: rtl/vmem_port_ctrl.sv
// Shares one synchronous single-port RAM between a scalar requester and a
// strided vector burst engine; read data returns one cycle after the grant.
module vmem_port_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_req,
  input  logic                  s_we,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_gnt,
  output logic                  s_rvalid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  v_start,
  input  logic                  v_we,
  input  logic [ADDR_WIDTH-1:0] v_base,
  input  logic [ADDR_WIDTH-1:0] v_stride,
  input  logic [4:0]            v_len,
  input  logic [DATA_WIDTH-1:0] v_wdata,
  output logic                  v_elem_ack,
  output logic                  v_rvalid,
  output logic [DATA_WIDTH-1:0] v_rdata,
  output logic                  v_busy,
  output logic                  v_done,
  output logic                  ram_w,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  import vmem_pkg::*;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_tag_q, rd_tag_d;
  logic                  done_pend_q, done_pend_d;
  logic                  done_q, done_d;

  logic                  req_s, req_v;
  logic                  gnt_s, gnt_v;
  logic                  start_burst, start_empty, last_elem;
  logic [LEN_W-1:0]      len_clamped;

  // Scalar requests are masked during reset so no grant can leak out.
  assign req_s       = s_req & ~rst;
  assign req_v       = (state_q == ST_BURST);
  assign len_clamped = (v_len > MAX_LEN) ? MAX_LEN : v_len;
  assign start_burst = (state_q == ST_IDLE) && v_start && (v_len != '0);
  assign start_empty = (state_q == ST_IDLE) && v_start && (v_len == '0);
  assign last_elem   = (cnt_q == (len_q - LEN_ONE));

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_s_i (req_s),
    .req_v_i (req_v),
    .gnt_s_o (gnt_s),
    .gnt_v_o (gnt_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_burst)           state_d = ST_BURST;
      ST_BURST: if (gnt_v && last_elem)    state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    v_busy     = (state_q == ST_BURST);
    s_gnt      = gnt_s;
    v_elem_ack = gnt_v;
    ram_w      = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    if (gnt_v) begin
      ram_w    = we_q;
      ram_addr = addr_q;
      ram_din  = we_q ? v_wdata : '0;
    end else if (gnt_s) begin
      ram_w    = s_we;
      ram_addr = s_addr;
      ram_din  = s_we ? s_wdata : '0;
    end
  end

  // Read data is shared; only the strobes carry the requester tag.
  assign s_rvalid = rd_valid_q && (rd_tag_q == TAG_S);
  assign v_rvalid = rd_valid_q && (rd_tag_q == TAG_V);
  assign s_rdata  = rst ? '0 : ram_dout;
  assign v_rdata  = rst ? '0 : ram_dout;
  assign v_done   = done_q;

  // The accumulator walks base, base+stride, ... so no multiplier is needed.
  always_comb begin
    we_d     = we_q;
    stride_d = stride_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    if (start_burst) begin
      we_d     = v_we;
      stride_d = v_stride;
      len_d    = len_clamped;
      cnt_d    = '0;
      addr_d   = v_base;
    end else if (gnt_v) begin
      cnt_d  = cnt_q + LEN_ONE;
      addr_d = addr_q + stride_q;
    end
  end

  // A read burst finishes only once its last data has been returned.
  always_comb begin
    rd_valid_d  = (gnt_v && !we_q) || (gnt_s && !s_we);
    rd_tag_d    = gnt_v ? TAG_V : TAG_S;
    done_pend_d = gnt_v && last_elem && !we_q;
    done_d      = done_pend_q || (gnt_v && last_elem && we_q) || start_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b0;
      stride_q    <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_tag_q    <= TAG_S;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      we_q        <= we_d;
      stride_q    <= stride_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_tag_q    <= rd_tag_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_vmem_port_ctrl.sv
// Self-checking bench for vmem_port_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level model.
module tb_vmem_port_ctrl;

  localparam int    AW    = 17;
  localparam int    DW    = 32;
  localparam longint AMASK = (longint'(1) << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_req, s_we, s_gnt, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          v_start, v_we, v_elem_ack, v_rvalid, v_busy, v_done;
  logic [AW-1:0] v_base, v_stride;
  logic [4:0]    v_len;
  logic [DW-1:0] v_wdata, v_rdata;
  logic          ram_w;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  int checks = 0;
  int errors = 0;

  vmem_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_req      (s_req),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_gnt      (s_gnt),
    .s_rvalid   (s_rvalid),
    .s_rdata    (s_rdata),
    .v_start    (v_start),
    .v_we       (v_we),
    .v_base     (v_base),
    .v_stride   (v_stride),
    .v_len      (v_len),
    .v_wdata    (v_wdata),
    .v_elem_ack (v_elem_ack),
    .v_rvalid   (v_rvalid),
    .v_rdata    (v_rdata),
    .v_busy     (v_busy),
    .v_done     (v_done),
    .ram_w      (ram_w),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous, one-cycle read latency.
  logic [DW-1:0] envMem [int];
  always @(posedge clk) begin : envRam
    int a;
    a = int'(ram_addr);
    ram_dout <= envMem.exists(a) ? envMem[a] : '0;
    if (ram_w) envMem[a] = ram_din;
  end

  // Reference model state, kept at transaction level.
  logic [DW-1:0] modelMem [int];
  int            vq[$];
  bit            mBurst, mVwe, mLastV, mPendRd, mPendTagV, mDone, mDone2;
  logic [DW-1:0] mPendData;

  function automatic logic [DW-1:0] modelRead(input int a);
    return modelMem.exists(a) ? modelMem[a] : '0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    envMem[a]   = d;
    modelMem[a] = d;
  endtask

  task automatic applyStimulus(input bit sreq, input bit swe, input logic [AW-1:0] saddr,
                               input logic [DW-1:0] swdata, input bit vstart, input bit vwe,
                               input logic [AW-1:0] vbase, input logic [AW-1:0] vstride,
                               input logic [4:0] vlen, input logic [DW-1:0] vwdata);
    @(posedge clk);
    #1;
    s_req = sreq; s_we = swe; s_addr = saddr; s_wdata = swdata;
    v_start = vstart; v_we = vwe; v_base = vbase; v_stride = vstride;
    v_len = vlen; v_wdata = vwdata;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic waitSample();
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin : compare
    bit            gs, gv, wasBurst, expW, nd, nd2;
    int            expA;
    logic [DW-1:0] expDin;
    if (rst) begin
      checkOutput("rst_s_gnt", s_gnt, 0);
      checkOutput("rst_s_rvalid", s_rvalid, 0);
      checkOutput("rst_s_rdata", s_rdata, 0);
      checkOutput("rst_v_elem_ack", v_elem_ack, 0);
      checkOutput("rst_v_rvalid", v_rvalid, 0);
      checkOutput("rst_v_rdata", v_rdata, 0);
      checkOutput("rst_v_busy", v_busy, 0);
      checkOutput("rst_v_done", v_done, 0);
      checkOutput("rst_ram_w", ram_w, 0);
      checkOutput("rst_ram_addr", ram_addr, 0);
      checkOutput("rst_ram_din", ram_din, 0);
      mBurst = 0; mVwe = 0; mLastV = 1; mPendRd = 0; mPendTagV = 0;
      mDone = 0; mDone2 = 0;
      vq.delete();
    end else begin
      gs = 0; gv = 0;
      if (mBurst && s_req) begin
        if (mLastV) gs = 1;
        else        gv = 1;
      end else begin
        gs = s_req;
        gv = mBurst;
      end
      expW = 0; expA = 0; expDin = '0;
      if (gv) begin
        expW = mVwe; expA = vq[0]; expDin = v_wdata;
      end else if (gs) begin
        expW = s_we; expA = int'(s_addr); expDin = s_wdata;
      end
      checkOutput("s_gnt", s_gnt, gs);
      checkOutput("v_elem_ack", v_elem_ack, gv);
      checkOutput("ram_w", ram_w, expW);
      checkOutput("v_busy", v_busy, mBurst);
      checkOutput("v_done", v_done, mDone);
      checkOutput("s_rvalid", s_rvalid, mPendRd && !mPendTagV);
      checkOutput("v_rvalid", v_rvalid, mPendRd && mPendTagV);
      if (gs || gv) checkOutput("ram_addr", ram_addr, 64'(expA));
      if (expW)     checkOutput("ram_din", ram_din, expDin);
      if (mPendRd && !mPendTagV) checkOutput("s_rdata", s_rdata, mPendData);
      if (mPendRd &&  mPendTagV) checkOutput("v_rdata", v_rdata, mPendData);

      wasBurst = mBurst;
      nd  = mDone2;
      nd2 = 0;
      mPendRd   = (gs || gv) && !expW;
      mPendTagV = gv;
      if (mPendRd) mPendData = modelRead(expA);
      if (expW)    modelMem[expA] = expDin;
      if (gs || gv) mLastV = gv;
      if (gv) begin
        void'(vq.pop_front());
        if (vq.size() == 0) begin
          mBurst = 0;
          if (mVwe) nd = 1;
          else      nd2 = 1;
        end
      end
      if (!wasBurst && v_start) begin
        if (v_len == 0) nd = 1;
        else begin
          mBurst = 1;
          mVwe   = v_we;
          vq.delete();
          for (int k = 0; k < int'(v_len); k++)
            vq.push_back(int'((longint'(v_base) + longint'(k) * longint'(v_stride)) & AMASK));
        end
      end
      mDone  = nd;
      mDone2 = nd2;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [AW-1:0] addrs[$];
    logic [DW-1:0] rdat[$];
    int lastRv, doneCyc, nS, nV, nRv, nDone, prevV, altBad, timeout;
    logic [AW-1:0] expAddr [4];
    logic [DW-1:0] expData [4];
    bit sr, sw, vs;
    logic [AW-1:0] sa, vb, vst;
    int sel;

    s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    v_start = 0; v_we = 0; v_base = '0; v_stride = '0; v_len = '0; v_wdata = '0;
    preload('h10, 32'hDEADBEEF);
    preload('h1FFFE, 32'h1111_0001);
    preload('h1FFFF, 32'h1111_0002);
    preload('h00000, 32'h1111_0003);
    preload('h00001, 32'h1111_0004);
    for (int i = 0; i < 8; i++) preload('h300 + i, 32'hA5A5_0000 + i);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    waitSample();
    checkOutput("reset_busy", v_busy, 0);
    checkOutput("reset_ram_w", ram_w, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Scalar read of a preloaded word.
    applyStimulus(1, 0, 'h10, '0, 0, 0, '0, '0, '0, '0);
    waitSample();
    checkOutput("sread_gnt", s_gnt, 1);
    checkOutput("sread_addr", ram_addr, 'h10);
    applyIdle();
    waitSample();
    checkOutput("sread_rvalid", s_rvalid, 1);
    checkOutput("sread_rdata", s_rdata, 32'hDEADBEEF);

    // Vector read wrapping past the top of the address space.
    expAddr = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    expData = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004};
    applyStimulus(0, 0, '0, '0, 1, 0, 'h1FFFE, 'd1, 5'd4, '0);
    lastRv = -1; doneCyc = -1;
    for (int c = 0; c < 12; c++) begin
      applyIdle();
      waitSample();
      if (v_elem_ack) addrs.push_back(ram_addr);
      if (v_rvalid) begin rdat.push_back(v_rdata); lastRv = c; end
      if (v_done && doneCyc < 0) doneCyc = c;
    end
    checkOutput("vread_naddr", addrs.size(), 4);
    checkOutput("vread_nrvalid", rdat.size(), 4);
    for (int i = 0; i < 4 && i < addrs.size(); i++) checkOutput("vread_addr", addrs[i], expAddr[i]);
    for (int i = 0; i < 4 && i < rdat.size(); i++)  checkOutput("vread_data", rdat[i], expData[i]);
    checkOutput("vread_done_cycle", doneCyc, 5);
    checkOutput("vread_done_after_rv", doneCyc, lastRv + 1);

    // Vector write contending with a continuous scalar read.
    applyStimulus(1, 0, 'h40, '0, 1, 1, 'h200, 'd4, 5'd3, 32'hC0DE0000);
    nS = 0; nV = 0; prevV = -1; altBad = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 0, 'h40, '0, 0, 0, '0, '0, '0, 32'hC0DE0001 + c);
      waitSample();
      nS += int'(s_gnt);
      nV += int'(v_elem_ack);
      if (int'(s_gnt) + int'(v_elem_ack) != 1) altBad++;
      if (prevV == int'(v_elem_ack)) altBad++;
      prevV = int'(v_elem_ack);
    end
    checkOutput("vwrite_acks", nV, 3);
    checkOutput("vwrite_total", nS + nV, 6);
    checkOutput("vwrite_alternate", altBad, 0);
    repeat (3) applyIdle();

    // Zero-length burst: no access, single done pulse, never busy.
    applyStimulus(0, 0, '0, '0, 1, 0, 'h55, 'd1, 5'd0, '0);
    waitSample();
    checkOutput("zlen_ram_w", ram_w, 0);
    checkOutput("zlen_ack", v_elem_ack, 0);
    checkOutput("zlen_busy", v_busy, 0);
    applyIdle();
    waitSample();
    checkOutput("zlen_done", v_done, 1);
    checkOutput("zlen_busy_after", v_busy, 0);
    applyIdle();
    waitSample();
    checkOutput("zlen_done_single", v_done, 0);

    // Reset in the middle of an 8-element read burst.
    applyStimulus(0, 0, '0, '0, 1, 0, 'h300, 'd1, 5'd8, '0);
    nRv = 0; timeout = 1;
    for (int c = 0; c < 20; c++) begin
      applyIdle();
      waitSample();
      if (v_rvalid) nRv++;
      if (nRv == 2) begin timeout = 0; break; end
    end
    checkOutput("abort_wait_rvalid_timeout", timeout, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_busy", v_busy, 0);
    checkOutput("abort_ack", v_elem_ack, 0);
    checkOutput("abort_rvalid", v_rvalid, 0);
    checkOutput("abort_ram_w", ram_w, 0);
    checkOutput("abort_ram_addr", ram_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nRv = 0; nDone = 0;
    for (int c = 0; c < 12; c++) begin
      applyIdle();
      waitSample();
      nRv += int'(v_rvalid);
      nDone += int'(v_done);
    end
    checkOutput("abort_no_rvalid", nRv, 0);
    checkOutput("abort_no_done", nDone, 0);
    applyStimulus(0, 0, '0, '0, 1, 0, 'h300, 'd1, 5'd2, '0);
    nRv = 0; nDone = 0;
    for (int c = 0; c < 10; c++) begin
      applyIdle();
      waitSample();
      nRv += int'(v_rvalid);
      nDone += int'(v_done);
    end
    checkOutput("postreset_rvalid", nRv, 2);
    checkOutput("postreset_done", nDone, 1);

    // Randomized traffic checked cycle by cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      sr = ($urandom_range(0, 99) < 55);
      sw = ($urandom_range(0, 1) == 1);
      sa = AW'('h300 + $urandom_range(0, 31));
      vs = ($urandom_range(0, 7) == 0);
      vb = ($urandom_range(0, 3) == 0) ? AW'('h1FFF0 + $urandom_range(0, 15))
                                       : AW'('h300 + $urandom_range(0, 15));
      sel = $urandom_range(0, 4);
      case (sel)
        0:       vst = '0;
        1:       vst = AW'(1);
        2:       vst = AW'(3);
        3:       vst = '1;
        default: vst = AW'($urandom);
      endcase
      applyStimulus(sr, sw, sa, $urandom, vs, ($urandom_range(0, 1) == 1), vb, vst,
                    5'($urandom_range(0, 16)), $urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    applyIdle();
    rst = 1'b0;
    repeat (25) applyIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
